// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the sequential CPU control unit:
// opcodes, FSM state encodings and instruction field extractors.
package cpu_ctrl_pkg;

   localparam logic [2:0] OP_ADD   = 3'd0;
   localparam logic [2:0] OP_AND   = 3'd1;
   localparam logic [2:0] OP_NOT   = 3'd2;
   localparam logic [2:0] OP_LOAD  = 3'd3;
   localparam logic [2:0] OP_STORE = 3'd4;
   localparam logic [2:0] OP_JUMP  = 3'd5;
   localparam logic [2:0] OP_JUMPZ = 3'd6;
   localparam logic [2:0] OP_HALT  = 3'd7;

   typedef enum logic [2:0] {
      ST_BOOT  = 3'd0,
      ST_FETCH = 3'd1,
      ST_DEC   = 3'd2,
      ST_EXEC  = 3'd3,
      ST_MEM   = 3'd4,
      ST_WB    = 3'd5,
      ST_HALT  = 3'd6
   } state_t;

   // Generic bit-field extract; widths are runtime ints so the
   // same helpers serve every parametrisation of the control unit.
   function automatic logic [31:0] f_field(
      input logic [31:0] v,
      input int          lsb,
      input int          w
   );
      logic [31:0] mask;
      mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
      return (v >> lsb) & mask;
   endfunction

   function automatic logic [31:0] f_op(
      input logic [31:0] v,
      input int          iw
   );
      return f_field(v, iw - 3, 3);
   endfunction

   function automatic logic [31:0] f_rd(
      input logic [31:0] v,
      input int          ow,
      input int          rw
   );
      return f_field(v, ow, rw);
   endfunction

   function automatic logic [31:0] f_off(
      input logic [31:0] v,
      input int          ow
   );
      return f_field(v, 0, ow);
   endfunction

   function automatic logic [31:0] f_ra(
      input logic [31:0] v,
      input int          ow,
      input int          rw
   );
      return f_field(v, ow - rw, rw);
   endfunction

   function automatic logic [31:0] f_rb(
      input logic [31:0] v,
      input int          ow,
      input int          rw
   );
      return f_field(v, ow - 2 * rw, rw);
   endfunction

endpackage

// File: rtl/ctrl_state_reg.sv
// FSM state register of the control unit.
// Asynchronous active-low reset forces BOOT.
module ctrl_state_reg
   import cpu_ctrl_pkg::*;
(
   input  logic   clk,
   input  logic   reset_n,
   input  state_t state_d,
   output state_t state_q
);

   // state flop; reset aborts whatever the FSM was doing
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_BOOT;
      else          state_q <= state_d;
   end

endmodule

// File: rtl/seq_control_unit.sv
// Multi-cycle CPU control unit: fetch/decode/execute/memory/writeback
// sequencing with req/ready memory handshakes and a resumable HALT.
module seq_control_unit
   import cpu_ctrl_pkg::*;
#(
   parameter  int REG_SEL_W = 1,
   parameter  int OFFSET_W  = 4,
   localparam int IW        = 3 + REG_SEL_W + OFFSET_W,
   localparam int NREG      = 2 ** REG_SEL_W
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [IW-1:0]        instr,
   input  logic                 zf,
   input  logic                 mem_ready,
   input  logic                 resume,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic                 addr_sel,
   output logic [OFFSET_W-1:0]  addr_offset,
   output logic [REG_SEL_W-1:0] mem_sel,
   output logic                 mdr_we,
   output logic                 ir_we,
   output logic                 pc_we,
   output logic                 pc_sel,
   output logic [REG_SEL_W-1:0] pc_jmp_sel,
   output logic [OFFSET_W-1:0]  pc_offset,
   output logic [2:0]           alu_opcode,
   output logic [REG_SEL_W-1:0] alu_sel_a,
   output logic [REG_SEL_W-1:0] alu_sel_b,
   output logic                 alu_we,
   output logic                 zf_we,
   output logic                 reg_wsel,
   output logic [NREG-1:0]      reg_we,
   output logic                 halt,
   output logic [2:0]           state
);

   state_t state_d;
   state_t state_q;

   logic [31:0]          ir_ext;
   logic [2:0]           op;
   logic [REG_SEL_W-1:0] rd;
   logic [REG_SEL_W-1:0] ra;
   logic [REG_SEL_W-1:0] rb;
   logic [OFFSET_W-1:0]  off;

   ctrl_state_reg u_state (
      .clk     (clk),
      .reset_n (reset_n),
      .state_d (state_d),
      .state_q (state_q)
   );

   assign state  = state_q;
   assign ir_ext = 32'(instr);

   // split the IR into opcode, destination, offset and operand selects
   always_comb begin
      op  = 3'(f_op(ir_ext, IW));
      rd  = REG_SEL_W'(f_rd(ir_ext, OFFSET_W, REG_SEL_W));
      off = OFFSET_W'(f_off(ir_ext, OFFSET_W));
      ra  = REG_SEL_W'(f_ra(ir_ext, OFFSET_W, REG_SEL_W));
      rb  = REG_SEL_W'(f_rb(ir_ext, OFFSET_W, REG_SEL_W));
   end

   // next state and datapath controls from state, IR, zf and ready
   always_comb begin
      state_d     = state_q;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      addr_sel    = 1'b0;
      addr_offset = '0;
      mem_sel     = '0;
      mdr_we      = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      pc_sel      = 1'b0;
      pc_jmp_sel  = '0;
      pc_offset   = '0;
      alu_opcode  = 3'd0;
      alu_sel_a   = '0;
      alu_sel_b   = '0;
      alu_we      = 1'b0;
      zf_we       = 1'b0;
      reg_wsel    = 1'b0;
      reg_we      = '0;
      halt        = 1'b0;
      case (state_q)
         ST_BOOT: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = ST_DEC;
            end
         end
         ST_DEC: begin
            case (op)
               OP_LOAD, OP_STORE: state_d = ST_MEM;
               OP_HALT:           state_d = ST_HALT;
               default:           state_d = ST_EXEC;
            endcase
         end
         ST_EXEC: begin
            state_d = ST_FETCH;
            case (op)
               OP_ADD, OP_AND, OP_NOT: begin
                  alu_opcode = op;
                  alu_sel_a  = ra;
                  alu_sel_b  = (op == OP_NOT) ? '0 : rb;
                  alu_we     = 1'b1;
                  zf_we      = 1'b1;
                  state_d    = ST_WB;
               end
               OP_JUMP, OP_JUMPZ: begin
                  pc_jmp_sel = rd;
                  pc_offset  = off;
                  if (op == OP_JUMP || zf) begin
                     pc_sel = 1'b1;
                     pc_we  = 1'b1;
                  end
               end
               default: ;
            endcase
         end
         ST_MEM: begin
            // address and offset stay put for the whole wait
            mem_req     = 1'b1;
            addr_sel    = 1'b1;
            addr_offset = off;
            case (op)
               OP_LOAD: begin
                  mdr_we = mem_ready;
                  if (mem_ready) state_d = ST_WB;
               end
               OP_STORE: begin
                  mem_we  = 1'b1;
                  mem_sel = rd;
                  if (mem_ready) state_d = ST_FETCH;
               end
               default: begin
                  mem_req     = 1'b0;
                  addr_sel    = 1'b0;
                  addr_offset = '0;
                  state_d     = ST_FETCH;
               end
            endcase
         end
         ST_WB: begin
            state_d = ST_FETCH;
            case (op)
               OP_ADD, OP_AND, OP_NOT: begin
                  reg_wsel   = 1'b1;
                  reg_we[rd] = 1'b1;
               end
               OP_LOAD: begin
                  reg_we[rd] = 1'b1;
               end
               default: ;
            endcase
         end
         ST_HALT: begin
            halt = 1'b1;
            if (resume) state_d = ST_FETCH;
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

endmodule
